// File: rtl/axil_gpio_slave_if.sv
// AXI-Lite slave bus bundle for axil_gpio_slave; master drives requests,
// slave drives ready/response signals.
interface axil_gpio_slave_if #(
    parameter int unsigned ADDR_WIDTH = 9
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_gpio_slave.sv
// AXI-Lite GPIO peripheral, register-compatible with the SoC GPIO bridge map.
// Channel 2 is implemented only when AXIL_GPIO_DUAL_EN is defined.
module axil_gpio_slave #(
    parameter int unsigned GPIO_WIDTH   = 32,
    parameter int unsigned GPIO2_WIDTH  = 32,
    parameter logic [31:0] DEFAULT_DATA = 32'h0,
    parameter logic [31:0] DEFAULT_TRI  = 32'hFFFF_FFFF,
    parameter int unsigned ADDR_WIDTH   = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    axil_gpio_slave_if.slave       s_axi,
    input  logic [GPIO_WIDTH-1:0]  gpio_i,
    output logic [GPIO_WIDTH-1:0]  gpio_o,
    output logic [GPIO_WIDTH-1:0]  gpio_t,
    input  logic [GPIO2_WIDTH-1:0] gpio2_i,
    output logic [GPIO2_WIDTH-1:0] gpio2_o,
    output logic [GPIO2_WIDTH-1:0] gpio2_t,
    output logic                   irq_o
);
    localparam logic [6:0] REG_DATA  = 7'h00;
    localparam logic [6:0] REG_TRI   = 7'h01;
    localparam logic [6:0] REG_DATA2 = 7'h02;
    localparam logic [6:0] REG_TRI2  = 7'h03;
    localparam logic [6:0] REG_GIER  = 7'h47;
    localparam logic [6:0] REG_ISR   = 7'h48;
    localparam logic [6:0] REG_IER   = 7'h4A;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    logic                  aw_held, w_held, bvalid_q, rvalid_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           wdata_q, rdata_q, rd_word;
    logic [3:0]            wstrb_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [6:0]            wr_sel;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;

    assign s_axi.awready = !aw_held && !bvalid_q;
    assign s_axi.wready  = !w_held && !bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign aw_hs = s_axi.awvalid && !aw_held && !bvalid_q;
    assign w_hs  = s_axi.wvalid && !w_held && !bvalid_q;
    assign ar_hs = s_axi.arvalid && !rvalid_q;

    // Commit on the edge completing the later handshake; a held side supplies
    // its captured beat, the side completing now supplies the live bus value.
    assign commit  = (aw_hs || aw_held) && (w_hs || w_held);
    assign wr_sel  = aw_held ? aw_addr_q[8:2] : s_axi.awaddr[8:2];
    assign wr_data = w_held ? wdata_q : s_axi.wdata;
    assign wr_strb = w_held ? wstrb_q : s_axi.wstrb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
            end
            if (aw_hs) aw_addr_q <= s_axi.awaddr;
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
        end
    end

    // Channel 1 registers and input synchroniser
    logic [GPIO_WIDTH-1:0] data_q, tri_q, sync1_q, sync_q, prev_q;
    logic [31:0]           data_wr, tri_wr;

    assign data_wr = apply_strb(32'(data_q), wr_data, wr_strb);
    assign tri_wr  = apply_strb(32'(tri_q), wr_data, wr_strb);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= DEFAULT_DATA[GPIO_WIDTH-1:0];
            tri_q   <= DEFAULT_TRI[GPIO_WIDTH-1:0];
            sync1_q <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            if (commit && wr_sel == REG_DATA) data_q <= data_wr[GPIO_WIDTH-1:0];
            if (commit && wr_sel == REG_TRI)  tri_q  <= tri_wr[GPIO_WIDTH-1:0];
            sync1_q <= gpio_i;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    assign gpio_o = data_q;
    assign gpio_t = tri_q;

    logic        ch2_change;
    logic [31:0] rd_data2, rd_tri2;

`ifdef AXIL_GPIO_DUAL_EN
    localparam logic [1:0] CH_MASK = 2'b11;

    logic [GPIO2_WIDTH-1:0] data2_q, tri2_q, sync1_2_q, sync_2_q, prev_2_q;
    logic [31:0]            data2_wr, tri2_wr;

    assign data2_wr = apply_strb(32'(data2_q), wr_data, wr_strb);
    assign tri2_wr  = apply_strb(32'(tri2_q), wr_data, wr_strb);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data2_q   <= DEFAULT_DATA[GPIO2_WIDTH-1:0];
            tri2_q    <= DEFAULT_TRI[GPIO2_WIDTH-1:0];
            sync1_2_q <= '0;
            sync_2_q  <= '0;
            prev_2_q  <= '0;
        end else begin
            if (commit && wr_sel == REG_DATA2) data2_q <= data2_wr[GPIO2_WIDTH-1:0];
            if (commit && wr_sel == REG_TRI2)  tri2_q  <= tri2_wr[GPIO2_WIDTH-1:0];
            sync1_2_q <= gpio2_i;
            sync_2_q  <= sync1_2_q;
            prev_2_q  <= sync_2_q;
        end
    end

    assign gpio2_o    = data2_q;
    assign gpio2_t    = tri2_q;
    assign ch2_change = |((sync_2_q ^ prev_2_q) & tri2_q);
    assign rd_data2   = 32'((sync_2_q & tri2_q) | (data2_q & ~tri2_q));
    assign rd_tri2    = 32'(tri2_q);
`else
    localparam logic [1:0] CH_MASK = 2'b01;

    logic unused_gpio2;
    assign unused_gpio2 = ^gpio2_i;
    assign gpio2_o      = '0;
    assign gpio2_t      = '1;
    assign ch2_change   = 1'b0;
    assign rd_data2     = '0;
    assign rd_tri2      = '0;
`endif

    // Interrupt block: hardware set takes priority over a same-cycle toggle
    logic       gier_q, irq_q;
    logic [1:0] isr_q, ier_q, hw_set, sw_tgl;

    assign hw_set = {ch2_change, |((sync_q ^ prev_q) & tri_q)};
    assign sw_tgl = (commit && wr_sel == REG_ISR && wr_strb[0]) ? (wr_data[1:0] & CH_MASK) : 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gier_q <= 1'b0;
            ier_q  <= '0;
            isr_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (commit && wr_sel == REG_GIER && wr_strb[3]) gier_q <= wr_data[31];
            if (commit && wr_sel == REG_IER && wr_strb[0])  ier_q  <= wr_data[1:0] & CH_MASK;
            isr_q <= (isr_q ^ sw_tgl) | hw_set;
            irq_q <= gier_q && |(isr_q & ier_q);
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        rd_word = '0;
        case (s_axi.araddr[8:2])
            REG_DATA:  rd_word = 32'((sync_q & tri_q) | (data_q & ~tri_q));
            REG_TRI:   rd_word = 32'(tri_q);
            REG_DATA2: rd_word = rd_data2;
            REG_TRI2:  rd_word = rd_tri2;
            REG_GIER:  rd_word = {gier_q, 31'b0};
            REG_ISR:   rd_word = {30'b0, isr_q};
            REG_IER:   rd_word = {30'b0, ier_q};
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                           s_axi.araddr[1:0], aw_addr_q[1:0]};
endmodule

// File: tb/tb_axil_gpio_slave.sv
// Self-checking bench for axil_gpio_slave: directed scenarios plus randomized
// register traffic compared against a register-map level reference model.
`timescale 1ns/1ps
module tb_axil_gpio_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef AXIL_GPIO_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    axil_gpio_slave_if #(.ADDR_WIDTH(9)) bus ();

    logic [31:0] gin = '0, gout, gtri, g2in = '0, g2out, g2tri;
    logic        irq;

    axil_gpio_slave #(
        .GPIO_WIDTH(32), .GPIO2_WIDTH(32), .DEFAULT_DATA(32'h0),
        .DEFAULT_TRI(32'hFFFF_FFFF), .ADDR_WIDTH(9)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_axi(bus),
        .gpio_i(gin), .gpio_o(gout), .gpio_t(gtri),
        .gpio2_i(g2in), .gpio2_o(g2out), .gpio2_t(g2tri),
        .irq_o(irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register contents
    logic [31:0] m_data, m_tri, m_data2, m_tri2;
    logic        m_gier;
    logic [1:0]  m_ier, m_isr;
    logic [1:0]  m_mask;

    task automatic model_reset();
        m_data = 32'h0; m_tri = 32'hFFFF_FFFF; m_data2 = 32'h0; m_tri2 = 32'hFFFF_FFFF;
        m_gier = 1'b0; m_ier = 2'b00; m_isr = 2'b00;
        m_mask = DUAL ? 2'b11 : 2'b01;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a & 9'h1FC)
            9'h000: m_data = merge(m_data, d, s);
            9'h004: m_tri  = merge(m_tri, d, s);
            9'h008: if (DUAL) m_data2 = merge(m_data2, d, s);
            9'h00C: if (DUAL) m_tri2  = merge(m_tri2, d, s);
            9'h11C: if (s[3]) m_gier = d[31];
            9'h120: if (s[0]) m_isr = m_isr ^ (d[1:0] & m_mask);
            9'h128: if (s[0]) m_ier = d[1:0] & m_mask;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [8:0] a);
        case (a & 9'h1FC)
            9'h000:  return (gin & m_tri) | (m_data & ~m_tri);
            9'h004:  return m_tri;
            9'h008:  return DUAL ? ((g2in & m_tri2) | (m_data2 & ~m_tri2)) : 32'h0;
            9'h00C:  return DUAL ? m_tri2 : 32'h0;
            9'h11C:  return {m_gier, 31'b0};
            9'h120:  return {30'b0, m_isr};
            9'h128:  return {30'b0, m_ier};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_gier & |(m_isr & m_ier);
    endfunction

    // Input change seen by the model: any changed input-configured pin sets ISR[0]
    task automatic change_inputs(input logic [31:0] v);
        if (((gin ^ v) & m_tri) != 0) m_isr[0] = 1'b1;
        gin = v;
    endtask

    // order: 0 = AW and W together, 1 = AW then W, 2 = W then AW
    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, output bit ok, output bit b_now,
                             output logic [1:0] resp, output logic [31:0] o_b,
                             output logic [31:0] t_b, output logic irq_b, output bit b_clear);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0; ok = 0; b_now = 0; b_clear = 0;
        resp = 'x; o_b = 'x; t_b = 'x; irq_b = 1'bx;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = (order != 2);
        bus.wvalid  = (order != 1);
        while (!(aw_done && w_done) && n < 40) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            n++;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid  = 1'b0; end
            if (aw_done && !w_done) bus.wvalid  = 1'b1;
            if (w_done && !aw_done) bus.awvalid = 1'b1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (aw_done && w_done) begin
            b_now = bus.bvalid; resp = bus.bresp; o_b = gout; t_b = gtri; irq_b = irq;
        end
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        ok = aw_done && w_done && bus.bvalid;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        b_clear = !bus.bvalid;
    endtask

    task automatic axi_read(input logic [8:0] a, input int hold, output bit ok,
                            output logic [31:0] data, output logic [1:0] resp, output bit held_ok);
        int n;
        n = 0; ok = 0; held_ok = 1; data = 'x; resp = 'x;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        ok = bus.rvalid; data = bus.rdata; resp = bus.rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata !== data) held_ok = 0;
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        if (bus.rvalid) held_ok = 0;
    endtask

    task automatic test_reset();
        bit ok, bn, bc; logic [1:0] rs; logic [31:0] ob, tb_; logic ib;
        repeat (2) @(negedge clk);
        total++; if (gtri !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_gpio_t: got %h want ffffffff", gtri); end
        total++; if (gout !== 32'h0) begin bad++; $display("FAIL rst_gpio_o: got %h want 0", gout); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100)
            begin bad++; $display("FAIL rst_handshake: got %b want 11100", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
        total++; if (g2tri !== m_tri2 || g2out !== m_data2) begin bad++; $display("FAIL rst_gpio2: got t=%h o=%h want t=%h o=%h", g2tri, g2out, m_tri2, m_data2); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end

        // Move state away from reset values, then reset with AW held
        axi_write(9'h004, 32'h0, 4'hF, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h004, 32'h0, 4'hF);
        axi_write(9'h000, 32'h1234_5678, 4'hF, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h000, 32'h1234_5678, 4'hF);
        total++; if (gout !== 32'h1234_5678) begin bad++; $display("FAIL pre_rst_gpio_o: got %h want 12345678", gout); end
        @(negedge clk);
        bus.awaddr = 9'h000; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL aw_held_ready: got %b want 0", bus.awready); end
        rst = 1'b1;
        #1;
        total++; if (bus.bvalid !== 1'b0 || gtri !== 32'hFFFF_FFFF || gout !== 32'h0 || irq !== 1'b0)
            begin bad++; $display("FAIL midwrite_rst: got b=%b t=%h o=%h irq=%b want 0 ffffffff 0 0", bus.bvalid, gtri, gout, irq); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin bad++; $display("FAIL midwrite_rst_ready: got aw=%b w=%b want 1 1", bus.awready, bus.wready); end
        // A lone W beat must not commit against a pre-reset AW
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        @(negedge clk);
        total++; if (bus.bvalid !== 1'b0 || gout !== 32'h0) begin bad++; $display("FAIL held_cleared: got b=%b o=%h want 0 0", bus.bvalid, gout); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_write_order();
        bit ok, bn, bc; logic [1:0] rs; logic [31:0] ob, tb_; logic ib;
        axi_write(9'h004, 32'h0000_0000, 4'b0001, 2, ok, bn, rs, ob, tb_, ib, bc);
        model_write(9'h004, 32'h0000_0000, 4'b0001);
        total++; if (!ok || bn !== 1'b1) begin bad++; $display("FAIL tri_w_first_latency: ok=%b bvalid=%b want 1 1", ok, bn); end
        total++; if (tb_ !== m_tri) begin bad++; $display("FAIL tri_strobe: got %h want %h", tb_, m_tri); end
        total++; if (rs !== 2'b00 || !bc) begin bad++; $display("FAIL tri_bresp: got resp=%b cleared=%b want 00 1", rs, bc); end
        axi_write(9'h000, 32'hA5A5_A5A5, 4'hF, 2, ok, bn, rs, ob, tb_, ib, bc);
        model_write(9'h000, 32'hA5A5_A5A5, 4'hF);
        total++; if (!ok || bn !== 1'b1 || ob !== m_data) begin bad++; $display("FAIL data_w_first: ok=%b bvalid=%b o=%h want 1 1 %h", ok, bn, ob, m_data); end
    endtask

    task automatic test_back_to_back();
        bit ok, bn, bc; logic [1:0] rs; logic [31:0] ob, tb_, d; logic ib;
        for (int ord = 0; ord < 2; ord++) begin
            d = $urandom;
            axi_write(9'h000, d, 4'hF, ord, ok, bn, rs, ob, tb_, ib, bc);
            model_write(9'h000, d, 4'hF);
            total++; if (!ok || bn !== 1'b1 || ob !== m_data) begin bad++; $display("FAIL b2b_order%0d: ok=%b bvalid=%b o=%h want 1 1 %h", ord, ok, bn, ob, m_data); end
        end
        axi_write(9'h000, 32'hA5A5_A5A5, 4'hF, 1, ok, bn, rs, ob, tb_, ib, bc);
        model_write(9'h000, 32'hA5A5_A5A5, 4'hF);
    endtask

    task automatic test_read_data();
        bit ok, hok; logic [31:0] rd; logic [1:0] rs;
        change_inputs(32'h0000_1200);
        repeat (4) @(negedge clk);
        axi_read(9'h000, 3, ok, rd, rs, hok);
        total++; if (rd !== model_read(9'h000)) begin bad++; $display("FAIL read_data: got %h want %h", rd, model_read(9'h000)); end
        total++; if (!ok || !hok || rs !== 2'b00) begin bad++; $display("FAIL read_hold: rvalid=%b held=%b resp=%b want 1 1 00", ok, hok, rs); end
        axi_read(9'h006, 0, ok, rd, rs, hok);
        total++; if (rd !== model_read(9'h004)) begin bad++; $display("FAIL read_tri_lowbits: got %h want %h", rd, model_read(9'h004)); end
    endtask

    task automatic test_irq();
        bit ok, bn, bc, hok; logic [1:0] rs; logic [31:0] ob, tb_, rd; logic ib;
        axi_write(9'h11C, 32'h8000_0000, 4'b1000, 1, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h11C, 32'h8000_0000, 4'b1000);
        axi_write(9'h128, 32'h1, 4'b0001, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h128, 32'h1, 4'b0001);
        if (m_isr[0]) begin
            axi_write(9'h120, 32'h1, 4'b0001, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h120, 32'h1, 4'b0001);
        end
        @(negedge clk);
        total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_idle: got %b want %b", irq, model_irq()); end
        change_inputs(gin ^ 32'h0000_0200);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0 after edge k+2", irq); end
        @(negedge clk);
        total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_rise: got %b want %b after edge k+3", irq, model_irq()); end
        axi_read(9'h120, 0, ok, rd, rs, hok);
        total++; if (rd !== model_read(9'h120)) begin bad++; $display("FAIL isr_read: got %h want %h", rd, model_read(9'h120)); end
        axi_write(9'h120, 32'h1, 4'b0001, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h120, 32'h1, 4'b0001);
        total++; if (ib !== 1'b1) begin bad++; $display("FAIL irq_registered: got %b want 1 in cycle after commit edge", ib); end
        total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_clear: got %b want %b", irq, model_irq()); end
    endtask

    task automatic test_unmapped();
        bit ok, bn, bc, hok; logic [1:0] rs; logic [31:0] ob, tb_, rd; logic ib;
        axi_read(9'h1F0, 0, ok, rd, rs, hok);
        total++; if (rd !== 32'h0 || rs !== 2'b00) begin bad++; $display("FAIL unmapped_read: got %h resp=%b want 0 00", rd, rs); end
        axi_write(9'h1F0, $urandom, 4'hF, 0, ok, bn, rs, ob, tb_, ib, bc);
        total++; if (!ok || rs !== 2'b00) begin bad++; $display("FAIL unmapped_bresp: ok=%b resp=%b want 1 00", ok, rs); end
        total++; if (gout !== m_data || gtri !== m_tri) begin bad++; $display("FAIL unmapped_write: got o=%h t=%h want %h %h", gout, gtri, m_data, m_tri); end
    endtask

    task automatic test_channel2();
        bit ok, bn, bc, hok; logic [1:0] rs; logic [31:0] ob, tb_, rd; logic ib;
        axi_write(9'h008, 32'hFFFF_FFFF, 4'hF, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h008, 32'hFFFF_FFFF, 4'hF);
        axi_read(9'h008, 0, ok, rd, rs, hok);
        total++; if (rd !== model_read(9'h008)) begin bad++; $display("FAIL data2_read: got %h want %h", rd, model_read(9'h008)); end
        total++; if (g2tri !== m_tri2 || g2out !== m_data2) begin bad++; $display("FAIL gpio2_pads: got t=%h o=%h want %h %h", g2tri, g2out, m_tri2, m_data2); end
        axi_write(9'h128, 32'h3, 4'b0001, 0, ok, bn, rs, ob, tb_, ib, bc); model_write(9'h128, 32'h3, 4'b0001);
        axi_read(9'h128, 0, ok, rd, rs, hok);
        total++; if (rd !== model_read(9'h128)) begin bad++; $display("FAIL ier_ch2_bit: got %h want %h", rd, model_read(9'h128)); end
    endtask

    task automatic test_random();
        bit ok, bn, bc, hok; logic [1:0] rs; logic [31:0] ob, tb_, rd, d; logic ib;
        logic [8:0] bases [8];
        logic [8:0] a;
        logic [3:0] s;
        int ord;
        bases = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h11C, 9'h120, 9'h128, 9'h1F0};
        change_inputs($urandom);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 9'($urandom_range(0, 511));
            else a = bases[$urandom_range(0, 7)] | 9'($urandom_range(0, 3));
            d = $urandom; s = 4'($urandom_range(0, 15)); ord = $urandom_range(0, 2);
            axi_write(a, d, s, ord, ok, bn, rs, ob, tb_, ib, bc);
            model_write(a, d, s);
            total++; if (!ok || bn !== 1'b1 || rs !== 2'b00) begin bad++; $display("FAIL rnd_wr%0d: a=%h ok=%b bvalid=%b resp=%b", i, a, ok, bn, rs); end
            axi_read(a, $urandom_range(0, 2), ok, rd, rs, hok);
            total++; if (rd !== model_read(a) || !ok || !hok) begin bad++; $display("FAIL rnd_rd%0d: a=%h got %h want %h ok=%b held=%b", i, a, rd, model_read(a), ok, hok); end
            total++; if (gout !== m_data || gtri !== m_tri || irq !== model_irq())
                begin bad++; $display("FAIL rnd_pads%0d: got o=%h t=%h irq=%b want %h %h %b", i, gout, gtri, irq, m_data, m_tri, model_irq()); end
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();
        test_reset();
        test_write_order();
        test_back_to_back();
        test_read_data();
        test_irq();
        test_unmapped();
        test_channel2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
